avst_packet_gen: RTL and testbench
==================================

# avst_packet_gen

Parametrised Avalon-ST packet stimulus generator for the turbo-decoder ASIC test path. It produces framed packets in the input word format of the ASIC Avalon wrapper: SOP/EOP flags, a data-valid bit, control fields and LFSR payload. It honours sink backpressure and round-robins packets over several channels. It sits in the FPGA test harness ahead of the wrapper, replacing host-fed stimulus for long BER runs.

## Interface
- DATA_WIDTH, 32: Avalon-ST data width. Must be at least 32.
- PAYLOAD_WIDTH, 7: payload bits per word, packed in data[PAYLOAD_WIDTH-1:0]. Must be at most 8.
- NUM_CHANNELS, 1: number of channels in the round-robin.
- CHANNEL_WIDTH, 1: width of src_channel. Must be at least $clog2(NUM_CHANNELS), minimum 1.
- LEN_WIDTH, 16: width of the length, gap and packet-count configuration fields.
- LFSR_SEED, 31'h1: reset value of the payload LFSR. Must be nonzero.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_enable  in  1  run request; level-sensitive.
- cfg_len  in  LEN_WIDTH  words per packet. Values below 2 are clamped to 2.
- cfg_lead  in  LEN_WIDTH  number of leading words with zero payload.
- cfg_gap  in  LEN_WIDTH  idle cycles between packets.
- cfg_num_pkts  in  LEN_WIDTH  packets per run; 0 means run without limit.
- cfg_ctrl  in  6  control field placed in data[14:9] (TestMode, Enable_f, Sel_f, S1, S2, S3 in that order, MSB first).
- src_ready  in  1  sink ready. Ready latency is 0.
- src_valid  out  1  word valid.
- src_data  out  DATA_WIDTH  word.
- src_sop  out  1  start of packet.
- src_eop  out  1  end of packet.
- src_channel  out  CHANNEL_WIDTH  channel of the current packet.
- busy  out  1  high in SEND or GAP.
- done  out  1  high in DONE.
- pkt_count  out  LEN_WIDTH  number of completed packets in the current run.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE → SEND when cfg_enable=1. pkt_count clears on this transition.
- Packet parameters are latched at each SOP and used for the whole packet: len, lead, gap and ctrl. src_channel is not latched from configuration; it is owned by the channel counter.
- SEND: words are indexed by idx = 0..len-1. idx advances on each beat (src_valid & src_ready).
- On the EOP beat, pkt_count increments, then:
  - if cfg_num_pkts≠0 and pkt_count+1 = cfg_num_pkts → DONE;
  - else if cfg_enable=0 → IDLE;
  - else if gap=0 → SEND (the next packet's SOP is presented in the following cycle);
  - else → GAP.
- GAP counts gap cycles, then → SEND if cfg_enable=1, else → IDLE.
- DONE → IDLE when cfg_enable=0.
- Word format, all other bits 0:
  - data[PAYLOAD_WIDTH-1:0] = 0 when idx=0 or idx<lead; otherwise LFSR[PAYLOAD_WIDTH-1:0].
  - data[8] = (idx≠0).
  - data[14:9] = latched ctrl.
  - data[24] = sop.
  - data[25] = eop.
- src_sop = (idx=0). src_eop = (idx=len-1).
- LFSR: 31-bit Fibonacci, x^31+x^28+1. It advances only on the beat of a word whose payload came from the LFSR. It is not reset between packets.
- Channel counter increments modulo NUM_CHANNELS after each EOP beat.
- Deasserting cfg_enable never truncates a packet; the current packet always completes.

## Timing
- Reset values: src_valid=0, src_sop=0, src_eop=0, src_data=0, src_channel=0, busy=0, done=0, pkt_count=0, LFSR=LFSR_SEED, state=IDLE.
- Outputs are registered. The first SOP is valid 1 cycle after cfg_enable is sampled high in IDLE.
- While src_valid=1 and src_ready=0, src_data, src_sop, src_eop and src_channel hold stable.
- src_valid stays high within a packet. Throughput is 1 word per cycle while src_ready=1.
- With gap=0, packets are back-to-back: the EOP beat is followed by the SOP cycle.
- With gap=G, src_valid is low for exactly G cycles after the EOP beat.
- Reset mid-packet forces src_valid low immediately. No EOP is emitted; downstream discards the partial packet.
- len=2 with lead ≥ len: every payload is zero and the LFSR does not advance.

## Structure
- Package avst_gen_pkg holds:
  - state enum;
  - bit-offset constants: VALID_BIT=8, CTRL_LSB=9, SOP_BIT=24, EOP_BIT=25;
  - LFSR width and taps.
- Sub-module avst_lfsr: seedable 31-bit LFSR with an advance enable.

## Test plan
- Single packet: len=202, lead=2, gap=0, num_pkts=1, ready tied to 1 → exactly 202 beats.
  - SOP at beat 0 with data[8]=0; payload 0 at beats 0-1; EOP at beat 201.
  - Payload matches the reference LFSR from LFSR_SEED; done=1 afterwards.
- Random backpressure (ready low ~40%) → the beat sequence is identical to the ready=1 run, and data is stable during every stall cycle.
- NUM_CHANNELS=3, num_pkts=6, gap=4 → channels 0,1,2,0,1,2, with exactly 4 idle cycles between packets; pkt_count=6.
- cfg_enable dropped at idx=50 of len=100 → the packet completes to its EOP, then IDLE; no further SOP.
- cfg_len=0 → packets of 2 words (SOP, then EOP).
- Async reset asserted mid-packet → src_valid=0 immediately. After release and re-enable, the first payload equals the seed-derived value.

Source files
------------

// File: rtl/avst_gen_pkg.sv
// Shared types, word-layout bit offsets and LFSR definition for the Avalon-ST packet generator.
package avst_gen_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam int VALID_BIT  = 8;
  localparam int CTRL_LSB   = 9;
  localparam int CTRL_WIDTH = 6;
  localparam int SOP_BIT    = 24;
  localparam int EOP_BIT    = 25;

  // x^31 + x^28 + 1, Fibonacci form: taps on state bits 30 and 27
  localparam int LFSR_WIDTH = 31;
  localparam int LFSR_TAP_A = 30;
  localparam int LFSR_TAP_B = 27;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

  function automatic logic [31:0] pack_word(input logic [7:0]            payload,
                                            input logic                  idx_nz,
                                            input logic [CTRL_WIDTH-1:0] ctrl,
                                            input logic                  sop,
                                            input logic                  eop);
    logic [31:0] w;
    w                          = '0;
    w[7:0]                     = payload;
    w[VALID_BIT]               = idx_nz;
    w[CTRL_LSB +: CTRL_WIDTH]  = ctrl;
    w[SOP_BIT]                 = sop;
    w[EOP_BIT]                 = eop;
    return w;
  endfunction

endpackage

// File: rtl/avst_lfsr.sv
// Seedable 31-bit payload LFSR; exposes the low bits of the current and the next state
// so the generator can pick up the post-advance value in the same cycle it advances.
module avst_lfsr
  import avst_gen_pkg::*;
#(
  parameter int                    OUT_WIDTH = 7,
  parameter logic [LFSR_WIDTH-1:0] SEED      = LFSR_WIDTH'(1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
  output logic [OUT_WIDTH-1:0] cur_bits,
  output logic [OUT_WIDTH-1:0] nxt_bits
);

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_nxt;

  assign state_nxt = lfsr_step(state_q);
  assign cur_bits  = state_q[OUT_WIDTH-1:0];
  assign nxt_bits  = state_nxt[OUT_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= state_nxt;
    end
  end

endmodule

// File: rtl/avst_packet_gen.sv
// Avalon-ST framed packet generator: registered outputs, first SOP one cycle after enable,
// output word held stable while src_ready is low; packets round-robin over channels.
module avst_packet_gen
  import avst_gen_pkg::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter int          PAYLOAD_WIDTH = 7,
  parameter int          NUM_CHANNELS  = 1,
  parameter int          CHANNEL_WIDTH = 1,
  parameter int          LEN_WIDTH     = 16,
  parameter logic [30:0] LFSR_SEED     = 31'h1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_enable,
  input  logic [LEN_WIDTH-1:0]     cfg_len,
  input  logic [LEN_WIDTH-1:0]     cfg_lead,
  input  logic [LEN_WIDTH-1:0]     cfg_gap,
  input  logic [LEN_WIDTH-1:0]     cfg_num_pkts,
  input  logic [5:0]               cfg_ctrl,
  input  logic                     src_ready,
  output logic                     src_valid,
  output logic [DATA_WIDTH-1:0]    src_data,
  output logic                     src_sop,
  output logic                     src_eop,
  output logic [CHANNEL_WIDTH-1:0] src_channel,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_WIDTH-1:0]     pkt_count
);

  state_t                 state;
  logic [LEN_WIDTH-1:0]   idx_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   lead_q;
  logic [LEN_WIDTH-1:0]   gap_q;
  logic [5:0]             ctrl_q;
  logic [LEN_WIDTH-1:0]   gap_cnt;
  logic                   from_lfsr_q;

  logic                     beat;
  logic                     last_beat;
  logic                     adv_word;
  logic                     start_pkt;
  logic                     stop_pkt;
  logic                     lfsr_adv;
  logic [PAYLOAD_WIDTH-1:0] lfsr_cur;
  logic [PAYLOAD_WIDTH-1:0] lfsr_nxt;
  logic [PAYLOAD_WIDTH-1:0] lfsr_avail;
  logic [PAYLOAD_WIDTH-1:0] nxt_pay;
  logic [LEN_WIDTH-1:0]     idx_nxt;
  logic                     nxt_from_lfsr;
  logic                     nxt_eop;
  logic [31:0]              nxt_word;
  logic [31:0]              sop_word;
  logic [LEN_WIDTH-1:0]     cfg_len_c;
  logic [LEN_WIDTH-1:0]     pkt_count_inc;
  logic                     num_reached;
  logic [CHANNEL_WIDTH-1:0] chan_nxt;

  assign beat      = src_valid & src_ready;
  assign last_beat = beat & src_eop;
  assign adv_word  = beat & ~src_eop;

  // The LFSR steps on the beat of a word that consumed it, so the following word
  // must see the post-step value in the same cycle.
  assign lfsr_adv   = beat & from_lfsr_q;
  assign lfsr_avail = lfsr_adv ? lfsr_nxt : lfsr_cur;

  avst_lfsr #(
    .OUT_WIDTH (PAYLOAD_WIDTH),
    .SEED      (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .advance  (lfsr_adv),
    .cur_bits (lfsr_cur),
    .nxt_bits (lfsr_nxt)
  );

  assign cfg_len_c     = (cfg_len < LEN_WIDTH'(2)) ? LEN_WIDTH'(2) : cfg_len;
  assign idx_nxt       = idx_q + LEN_WIDTH'(1);
  assign nxt_from_lfsr = (idx_nxt >= lead_q);
  assign nxt_eop       = (idx_nxt == len_q - LEN_WIDTH'(1));
  assign nxt_pay       = nxt_from_lfsr ? lfsr_avail : '0;
  assign nxt_word      = pack_word(8'(nxt_pay), 1'b1, ctrl_q, 1'b0, nxt_eop);
  assign sop_word      = pack_word(8'h00, 1'b0, cfg_ctrl, 1'b1, 1'b0);

  assign pkt_count_inc = pkt_count + LEN_WIDTH'(1);
  assign num_reached   = (cfg_num_pkts != '0) && (pkt_count_inc == cfg_num_pkts);
  assign chan_nxt      = (src_channel == CHANNEL_WIDTH'(NUM_CHANNELS - 1)) ? '0
                                                                          : src_channel + CHANNEL_WIDTH'(1);

  always_comb begin
    start_pkt = 1'b0;
    stop_pkt  = 1'b0;
    case (state)
      IDLE: start_pkt = cfg_enable;
      SEND: begin
        if (last_beat) begin
          if (num_reached || !cfg_enable || (gap_q != '0)) stop_pkt  = 1'b1;
          else                                             start_pkt = 1'b1;
        end
      end
      GAP:  if (gap_cnt == '0) start_pkt = cfg_enable;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_count <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_enable) begin
            state     <= SEND;
            busy      <= 1'b1;
            pkt_count <= '0;
          end
        end
        SEND: begin
          if (last_beat) begin
            pkt_count <= pkt_count_inc;
            if (num_reached) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (!cfg_enable) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (gap_q != '0) begin
              state   <= GAP;
              gap_cnt <= gap_q - LEN_WIDTH'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (cfg_enable) begin
              state <= SEND;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt - LEN_WIDTH'(1);
          end
        end
        DONE: begin
          if (!cfg_enable) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output word register; packet parameters are captured together with the SOP word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_valid   <= 1'b0;
      src_data    <= '0;
      src_sop     <= 1'b0;
      src_eop     <= 1'b0;
      src_channel <= '0;
      idx_q       <= '0;
      len_q       <= LEN_WIDTH'(2);
      lead_q      <= '0;
      gap_q       <= '0;
      ctrl_q      <= '0;
      from_lfsr_q <= 1'b0;
    end else begin
      if (last_beat) begin
        src_channel <= chan_nxt;
      end
      if (start_pkt) begin
        src_valid   <= 1'b1;
        src_data    <= DATA_WIDTH'(sop_word);
        src_sop     <= 1'b1;
        src_eop     <= 1'b0;
        idx_q       <= '0;
        len_q       <= cfg_len_c;
        lead_q      <= cfg_lead;
        gap_q       <= cfg_gap;
        ctrl_q      <= cfg_ctrl;
        from_lfsr_q <= 1'b0;
      end else if (adv_word) begin
        src_data    <= DATA_WIDTH'(nxt_word);
        src_sop     <= 1'b0;
        src_eop     <= nxt_eop;
        idx_q       <= idx_nxt;
        from_lfsr_q <= nxt_from_lfsr;
      end else if (stop_pkt) begin
        src_valid   <= 1'b0;
        src_data    <= '0;
        src_sop     <= 1'b0;
        src_eop     <= 1'b0;
        from_lfsr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avst_packet_gen.sv
// Scoreboard bench for avst_packet_gen: stimulus queues expected beats from a reference model,
// a forked monitor compares every accepted beat and checks stall stability and inter-packet gaps.
module tb_avst_packet_gen;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 2;
  localparam int NCH = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_enable;
  logic [LW-1:0] cfg_len, cfg_lead, cfg_gap, cfg_num_pkts;
  logic [5:0]    cfg_ctrl;
  logic          src_ready;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_sop, src_eop;
  logic [CW-1:0] src_channel;
  logic          busy, done;
  logic [LW-1:0] pkt_count;

  avst_packet_gen #(
    .DATA_WIDTH(DW), .PAYLOAD_WIDTH(7), .NUM_CHANNELS(NCH), .CHANNEL_WIDTH(CW),
    .LEN_WIDTH(LW), .LFSR_SEED(31'h1)
  ) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_len(cfg_len), .cfg_lead(cfg_lead),
    .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts), .cfg_ctrl(cfg_ctrl), .src_ready(src_ready),
    .src_valid(src_valid), .src_data(src_data), .src_sop(src_sop), .src_eop(src_eop),
    .src_channel(src_channel), .busy(busy), .done(done), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    logic          sop;
    logic          eop;
    logic [CW-1:0] chan;
  } exp_t;

  exp_t exp_q[$];
  int   gaps_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beat_cnt = 0;
  int   rdy_mode = 0;

  logic [30:0]   m_lfsr;
  logic [CW-1:0] m_chan;

  function automatic logic [30:0] ref_step(input logic [30:0] s);
    logic fb;
    fb = ((s >> 30) & 31'h1) != ((s >> 27) & 31'h1);
    return (s << 1) | 31'(fb);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_pkt(input int len, input int lead, input logic [5:0] ctrl);
    int   l;
    exp_t e;
    logic [6:0] pay;
    l = (len < 2) ? 2 : len;
    for (int i = 0; i < l; i++) begin
      pay = 7'h0;
      if (i != 0 && i >= lead) begin
        pay    = m_lfsr[6:0];
        m_lfsr = ref_step(m_lfsr);
      end
      e.sop  = (i == 0);
      e.eop  = (i == l - 1);
      e.chan = m_chan;
      e.data = 32'(pay) | (32'(i != 0) << 8) | (32'(ctrl) << 9)
             | (32'(e.sop) << 24) | (32'(e.eop) << 25);
      exp_q.push_back(e);
    end
    m_chan = (m_chan == CW'(NCH - 1)) ? '0 : m_chan + CW'(1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    cfg_enable = 1'b0;
    #1;
    exp_q.delete();
    gaps_q.delete();
    m_lfsr = 31'h1;
    m_chan = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_cfg(input int len, input int lead, input int gap, input int num, input logic [5:0] ctrl);
    @(posedge clk);
    #1;
    cfg_len = LW'(len); cfg_lead = LW'(lead); cfg_gap = LW'(gap);
    cfg_num_pkts = LW'(num); cfg_ctrl = ctrl;
    cfg_enable = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: drain timeout, %0d beats still outstanding", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t          e;
    logic          prev_stall = 1'b0;
    logic          gap_track = 1'b0;
    int            gap_ctr = 0;
    logic [DW-1:0] h_data;
    logic          h_sop, h_eop;
    logic [CW-1:0] h_chan;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        gap_track  = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold", {src_valid, src_sop, src_eop, src_channel, src_data},
                            {1'b1, h_sop, h_eop, h_chan, h_data});
        end
        if (gap_track && src_valid) begin
          gaps_q.push_back(gap_ctr);
          gap_track = 1'b0;
        end else if (gap_track) begin
          gap_ctr++;
        end
        prev_stall = src_valid && !src_ready;
        h_data = src_data; h_sop = src_sop; h_eop = src_eop; h_chan = src_channel;
        if (src_valid && src_ready) begin
          beat_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h with no beat expected", src_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {src_sop, src_eop, src_channel, src_data}, {e.sop, e.eop, e.chan, e.data});
          end
          if (src_eop) begin
            gap_track = 1'b1;
            gap_ctr   = 0;
          end
        end
      end
    end
  endtask

  initial begin
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      src_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 40);
    end
  end

  initial begin
    int b0;
    int n;
    reset = 1'b1; cfg_enable = 1'b0;
    cfg_len = '0; cfg_lead = '0; cfg_gap = '0; cfg_num_pkts = '0; cfg_ctrl = '0;
    fork monitor(); join_none
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_outputs", {src_valid, src_sop, src_eop, src_channel, busy, done}, 0);
    chk("rst_data", src_data, 0);
    chk("rst_pkt_count", pkt_count, 0);

    // Single packet, ready tied high, with first-SOP latency
    rdy_mode = 0;
    expect_pkt(202, 2, 6'h2A);
    b0 = beat_cnt;
    run_cfg(202, 2, 0, 1, 6'h2A);
    @(negedge clk);
    chk("sop_not_early", src_valid, 0);
    @(negedge clk);
    chk("sop_latency", {src_valid, src_sop, busy}, 3'b111);
    wait_drain("single", 600);
    chk("single_beats", beat_cnt - b0, 202);
    chk("single_done", {done, busy}, 2'b10);
    chk("single_pkt_count", pkt_count, 1);
    cfg_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_clear", done, 0);

    // Same run under random backpressure
    do_reset();
    rdy_mode = 1;
    expect_pkt(202, 2, 6'h2A);
    b0 = beat_cnt;
    run_cfg(202, 2, 0, 1, 6'h2A);
    wait_drain("backpressure", 3000);
    chk("bp_beats", beat_cnt - b0, 202);
    chk("bp_done", done, 1);
    rdy_mode = 0;

    // Channel round-robin with gaps
    do_reset();
    for (int p = 0; p < 6; p++) expect_pkt(5, 1, 6'h15);
    run_cfg(5, 1, 4, 6, 6'h15);
    wait_drain("channels", 600);
    chk("chan_pkt_count", pkt_count, 6);
    chk("chan_done", done, 1);
    chk("gap_entries", gaps_q.size(), 5);
    foreach (gaps_q[i]) chk("gap_len", gaps_q[i], 4);
    cfg_enable = 1'b0;

    // Enable dropped mid-packet
    do_reset();
    expect_pkt(100, 0, 6'h3F);
    b0 = beat_cnt;
    run_cfg(100, 0, 0, 0, 6'h3F);
    n = 0;
    while (beat_cnt - b0 < 50 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drop_reach_idx50", (beat_cnt - b0 >= 50), 1);
    #1 cfg_enable = 1'b0;
    wait_drain("drop", 600);
    repeat (20) @(negedge clk);
    chk("drop_beats", beat_cnt - b0, 100);
    chk("drop_idle", {busy, done, src_valid}, 0);
    chk("drop_pkt_count", pkt_count, 1);

    // Length clamp
    do_reset();
    expect_pkt(0, 0, 6'h01);
    expect_pkt(0, 0, 6'h01);
    b0 = beat_cnt;
    run_cfg(0, 0, 0, 2, 6'h01);
    wait_drain("len_clamp", 200);
    chk("clamp_beats", beat_cnt - b0, 4);
    chk("clamp_pkt_count", pkt_count, 2);
    cfg_enable = 1'b0;

    // lead >= len keeps the LFSR parked; next run's first payload is the seed value
    do_reset();
    expect_pkt(2, 5, 6'h20);
    run_cfg(2, 5, 0, 1, 6'h20);
    wait_drain("lead_all", 200);
    cfg_enable = 1'b0;
    repeat (3) @(posedge clk);
    expect_pkt(2, 0, 6'h20);
    run_cfg(2, 0, 0, 1, 6'h20);
    wait_drain("lead_after", 200);
    chk("lead_after_done", done, 1);
    cfg_enable = 1'b0;

    // Async reset mid-packet, then a fresh run
    do_reset();
    expect_pkt(100, 0, 6'h0C);
    b0 = beat_cnt;
    run_cfg(100, 0, 0, 0, 6'h0C);
    n = 0;
    while (beat_cnt - b0 < 20 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {src_valid, src_sop, src_eop}, 0);
    do_reset();
    expect_pkt(3, 0, 6'h0C);
    run_cfg(3, 0, 0, 1, 6'h0C);
    wait_drain("post_reset", 200);
    chk("post_reset_done", {done, pkt_count}, {1'b1, 16'd1});
    cfg_enable = 1'b0;

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
